op_seq_ctrl: RTL and testbench
==============================

Name: op_seq_ctrl

Overview:
Instruction sequencer for the ADDI/SUBI/ANDI/XORI/JMP/JMPC/CALL opcode set over the 4-entry register file (REG0..REG3).
- Fetches 16-bit instructions from an external instruction memory using a req/valid handshake.
- Decodes and executes them against an internal 4x8 register file and carry/zero flags.
- Manages the PC and a small call stack.
- Sits between the instruction memory and the ALU/regfile datapath; the bench drives it by loading a program and pulsing start.

Parameters:
PC_W, 8, program counter width (1..8); jump targets use imm[PC_W-1:0]
STACK_DEPTH, 4, call-stack entries (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  single-cycle pulse; starts execution at start_pc (ignored unless state IDLE or HALT)
start_pc  in  PC_W  initial PC, sampled with start
imem_req  out  1  fetch request
imem_addr  out  PC_W  fetch address (= pc)
imem_valid  in  1  instruction data valid
imem_data  in  16  instruction word
busy  out  1  high in FETCH/EXEC
halted  out  1  high in HALT
err  out  1  sticky stack overflow flag; cleared by start or reset
rf_q  out  32  register file, REGn at [8n+7:8n]
carry  out  1  carry/borrow flag
zero  out  1  zero flag

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=0, sp=0, rf=0, carry=0, zero=0.
  - imem_req=0, imem_addr=0, busy=0, halted=0, err=0.
  - Reset mid-fetch or mid-exec aborts the operation with no partial register write.
- Instruction word: [15:13] op, [12:11] reg, [10:8] reserved (ignored), [7:0] imm.
- FSM states: IDLE, FETCH, EXEC, HALT.
  - IDLE/HALT + start: pc<=start_pc, sp<=0, err<=0, carry<=0, zero<=0, halted<=0 -> FETCH. The register file is NOT cleared.
  - FETCH: imem_req=1 and imem_addr=pc are held until imem_valid is sampled high. Then the instruction is latched -> EXEC. imem_valid in the same cycle as req is legal, giving a minimum of 2 cycles per instruction. imem_valid while imem_req=0 is ignored.
  - EXEC: one cycle; performs the operation below -> FETCH, or -> HALT.
- Operations (all 8-bit, modulo 256; pc increments modulo 2^PC_W):
  - ADDI: {carry,rf[reg]} <= rf[reg]+imm; zero <= (result==0); pc+1.
  - SUBI: rf[reg] <= rf[reg]-imm; carry <= borrow (rf[reg]<imm); zero updated; pc+1.
  - ANDI / XORI: rf[reg] <= rf[reg] & / ^ imm; zero updated; carry unchanged; pc+1.
  - JMP: pc <= imm[PC_W-1:0]; flags unchanged.
  - JMPC: if carry, pc <= imm, else pc+1.
  - CALL:
    - If sp<STACK_DEPTH: push pc+1, sp+1, pc <= imm.
    - Else: err<=1, -> HALT, pc unchanged.
  - RET (op 3'd7):
    - If sp>0: pop into pc.
    - If sp==0: normal program end -> HALT, err unchanged.
- The reg field is ignored for JMP/JMPC/CALL/RET.
- start asserted while busy: ignored, no effect.
- PC wrap: pc = 2^PC_W-1 followed by a non-branch instruction goes to 0.

Decomposition:
- Shared package seq_pkg:
  - op_t enum bit[2:0] {ADDI, SUBI, ANDI, XORI, JMP, JMPC, CALL, RET}; encodings 0..6 match the existing op_t.
  - reg_t enum bit[1:0] {REG0..REG3}.
  - state_t enum {IDLE, FETCH, EXEC, HALT}.
  - Instruction field-position localparams.
- One natural sub-module: op_seq_stack (LIFO of PC_W x STACK_DEPTH with push/pop/full/empty).
- The ALU stays inline.

Test Plan:
- Reset/idle: rst_n low for 3 cycles -> all outputs 0, imem_req=0. Then start with start_pc=0x10 -> next cycle imem_req=1, imem_addr=0x10, busy=1.
- Arithmetic: program ADDI REG1,0xF0; ADDI REG1,0x20; SUBI REG2,0x01; RET -> REG1=0x10 with carry=1 after the second ADDI; REG2=0xFF with carry=1, zero=0; then halted=1, err=0.
- Branching: ADDI REG0,0xFF; ADDI REG0,0x01 (REG0=0, carry=1, zero=1); JMPC 0x08 -> next imem_addr=0x08. Repeat with carry=0 -> imem_addr=pc+1.
- Handshake stall: imem_valid held low for 5 cycles -> imem_req and imem_addr stable throughout, no state change. Same-cycle valid -> exactly 2 cycles per instruction.
- Call stack: nested CALLs to depth 4, then RETs -> each return to caller+1. A 5th CALL -> err=1, halted=1, pc unchanged. A following start clears err.
- Reset mid-op: rst_n drops during EXEC of ADDI REG3,0x05 -> REG3=0, state IDLE immediately (asynchronous, no clock edge needed).

Source files
------------

// File: rtl/seq_pkg.sv
// seq_pkg: shared opcode, register and state types plus instruction field positions.
package seq_pkg;
   typedef enum logic [2:0] {ADDI, SUBI, ANDI, XORI, JMP, JMPC, CALL, RET} op_t;
   typedef enum logic [1:0] {REG0, REG1, REG2, REG3} reg_t;
   typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;
   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 13;
   localparam int REG_MSB = 12;
   localparam int REG_LSB = 11;
   localparam int IMM_MSB = 7;
   localparam int IMM_LSB = 0;
endpackage

// File: rtl/op_seq_stack.sv
// op_seq_stack: return-address LIFO with push/pop/clear and full/empty status.
module op_seq_stack #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int SW = $clog2(DEPTH + 1);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   logic [W-1:0]  mem [DEPTH];
   logic [SW-1:0] sp;
   logic [SW-1:0] top;
   assign top   = sp - 1'b1;
   assign dout  = mem[top[AW-1:0]];
   assign full  = sp == SW'(DEPTH);
   assign empty = sp == '0;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sp <= '0;
      else sp <= clr ? '0 : push ? sp + 1'b1 : pop ? sp - 1'b1 : sp;
   always_ff @(posedge clk)
      if (push) mem[sp[AW-1:0]] <= din;
endmodule

// File: rtl/op_seq_ctrl.sv
// op_seq_ctrl: fetch/execute sequencer over a 4x8 register file with flags and call stack.
module op_seq_ctrl
   import seq_pkg::*;
#(
   parameter int PC_W        = 8,
   parameter int STACK_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [PC_W-1:0] start_pc,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_valid,
   input  logic [15:0]     imem_data,
   output logic            busy,
   output logic            halted,
   output logic            err,
   output logic [31:0]     rf_q,
   output logic            carry,
   output logic            zero
);
   state_t          state, state_n;
   logic [PC_W-1:0] pc, pc_n, pc_inc, ret_pc;
   op_t             op, op_n;
   logic [1:0]      rsel, rsel_n;
   logic [7:0]      imm, imm_n;
   logic [3:0][7:0] rf, rf_n;
   logic            carry_n, zero_n, err_n;
   logic            push, pop, clr, full, empty;
   logic [8:0]      sum;
   assign imem_req  = state == FETCH;
   assign imem_addr = pc;
   assign busy      = state == FETCH || state == EXEC;
   assign halted    = state == HALT;
   assign rf_q      = rf;
   assign pc_inc    = pc + 1'b1;
   op_seq_stack #(.W(PC_W), .DEPTH(STACK_DEPTH)) u_stack (
      .clk(clk), .rst_n(rst_n), .clr(clr), .push(push), .pop(pop),
      .din(pc_inc), .dout(ret_pc), .full(full), .empty(empty)
   );
   always_comb begin
      state_n = state;
      pc_n    = pc;
      op_n    = op;
      rsel_n  = rsel;
      imm_n   = imm;
      rf_n    = rf;
      carry_n = carry;
      zero_n  = zero;
      err_n   = err;
      push    = 1'b0;
      pop     = 1'b0;
      clr     = 1'b0;
      sum     = '0;
      case (state)
         IDLE, HALT: if (start) begin
            pc_n    = start_pc;
            clr     = 1'b1;
            err_n   = 1'b0;
            carry_n = 1'b0;
            zero_n  = 1'b0;
            state_n = FETCH;
         end
         FETCH: if (imem_valid) begin
            op_n    = op_t'(imem_data[OP_MSB:OP_LSB]);
            rsel_n  = imem_data[REG_MSB:REG_LSB];
            imm_n   = imem_data[IMM_MSB:IMM_LSB];
            state_n = EXEC;
         end
         EXEC: begin
            state_n = FETCH;
            pc_n    = pc_inc;
            case (op)
               ADDI, SUBI: begin
                  sum        = op == ADDI ? {1'b0, rf[rsel]} + {1'b0, imm} : {1'b0, rf[rsel]} - {1'b0, imm};
                  rf_n[rsel] = sum[7:0];
                  carry_n    = sum[8];
                  zero_n     = sum[7:0] == 8'h00;
               end
               ANDI, XORI: begin
                  rf_n[rsel] = op == ANDI ? rf[rsel] & imm : rf[rsel] ^ imm;
                  zero_n     = rf_n[rsel] == 8'h00;
               end
               JMP:  pc_n = imm[PC_W-1:0];
               JMPC: pc_n = carry ? imm[PC_W-1:0] : pc_inc;
               CALL: begin
                  push    = !full;
                  err_n   = err | full;
                  pc_n    = full ? pc : imm[PC_W-1:0];
                  state_n = full ? HALT : FETCH;
               end
               default: begin
                  pop     = !empty;
                  pc_n    = empty ? pc : ret_pc;
                  state_n = empty ? HALT : FETCH;
               end
            endcase
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         pc    <= '0;
         op    <= ADDI;
         rsel  <= '0;
         imm   <= '0;
         rf    <= '0;
         carry <= 1'b0;
         zero  <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= state_n;
         pc    <= pc_n;
         op    <= op_n;
         rsel  <= rsel_n;
         imm   <= imm_n;
         rf    <= rf_n;
         carry <= carry_n;
         zero  <= zero_n;
         err   <= err_n;
      end
endmodule

// File: tb/tb_op_seq_ctrl.sv
// tb_op_seq_ctrl: directed scenario tests for op_seq_ctrl against a simple instruction memory.
module tb_op_seq_ctrl;
   import seq_pkg::*;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  start_pc = '0;
   logic        imem_req, imem_valid, busy, halted, err, carry, zero;
   logic [7:0]  imem_addr;
   logic [15:0] imem_data;
   logic [31:0] rf_q;
   logic [15:0] prog [256];
   logic        stall = 1'b0;
   logic        rec = 1'b0;
   logic [7:0]  fetched [$];
   int          checks = 0;
   int          failures = 0;

   op_seq_ctrl #(.PC_W(8), .STACK_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_data(imem_data),
      .busy(busy), .halted(halted), .err(err), .rf_q(rf_q), .carry(carry), .zero(zero)
   );

   always #5 clk = ~clk;
   assign imem_valid = imem_req & ~stall;
   assign imem_data  = prog[imem_addr];

   always @(negedge clk)
      if (rec && imem_req && imem_valid) fetched.push_back(imem_addr);

   function automatic logic [15:0] ins(input logic [2:0] op, input logic [1:0] r, input logic [7:0] imm);
      return {op, r, 3'b101, imm};
   endfunction

   task automatic kick(input logic [7:0] p);
      start_pc = p;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_halt(input string name);
      for (int i = 0; i < 200 && !halted; i++) @(negedge clk);
      checks++; if (halted !== 1'b1) begin failures++; $display("FAIL %s_halt_timeout got=%b exp=1", name, halted); end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", imem_req); end
      checks++; if (imem_addr !== 8'h00) begin failures++; $display("FAIL rst_addr got=%h exp=00", imem_addr); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
      checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rst_halted got=%b exp=0", halted); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err); end
      checks++; if (rf_q !== 32'h0) begin failures++; $display("FAIL rst_rf got=%h exp=0", rf_q); end
      checks++; if ({carry, zero} !== 2'b00) begin failures++; $display("FAIL rst_flags got=%b exp=00", {carry, zero}); end
      rst_n = 1'b1;
      @(negedge clk);
      kick(8'h10);
      checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL start_req got=%b exp=1", imem_req); end
      checks++; if (imem_addr !== 8'h10) begin failures++; $display("FAIL start_addr got=%h exp=10", imem_addr); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL start_busy got=%b exp=1", busy); end
      wait_halt("start");
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL start_err got=%b exp=0", err); end
   endtask

   task automatic test_arith;
      kick(8'h20);
      repeat (4) @(negedge clk);
      checks++; if (rf_q[15:8] !== 8'h10) begin failures++; $display("FAIL add_r1 got=%h exp=10", rf_q[15:8]); end
      checks++; if ({carry, zero} !== 2'b10) begin failures++; $display("FAIL add_flags got=%b exp=10", {carry, zero}); end
      repeat (2) @(negedge clk);
      checks++; if (rf_q[23:16] !== 8'hFF) begin failures++; $display("FAIL sub_r2 got=%h exp=ff", rf_q[23:16]); end
      checks++; if ({carry, zero} !== 2'b10) begin failures++; $display("FAIL sub_flags got=%b exp=10", {carry, zero}); end
      wait_halt("arith");
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL arith_err got=%b exp=0", err); end
   endtask

   task automatic test_branch;
      kick(8'h30);
      repeat (4) @(negedge clk);
      checks++; if (rf_q[7:0] !== 8'h00) begin failures++; $display("FAIL br_r0 got=%h exp=00", rf_q[7:0]); end
      checks++; if ({carry, zero} !== 2'b11) begin failures++; $display("FAIL br_flags got=%b exp=11", {carry, zero}); end
      repeat (2) @(negedge clk);
      checks++; if (imem_addr !== 8'h08) begin failures++; $display("FAIL jmpc_taken got=%h exp=08", imem_addr); end
      wait_halt("jmpc_taken");
      kick(8'h40);
      repeat (2) @(negedge clk);
      checks++; if (carry !== 1'b0) begin failures++; $display("FAIL nc_carry got=%b exp=0", carry); end
      repeat (2) @(negedge clk);
      checks++; if (imem_addr !== 8'h42) begin failures++; $display("FAIL jmpc_not_taken got=%h exp=42", imem_addr); end
      wait_halt("jmpc_nt");
      kick(8'hFF);
      repeat (2) @(negedge clk);
      checks++; if (imem_addr !== 8'h00) begin failures++; $display("FAIL pc_wrap got=%h exp=00", imem_addr); end
      checks++; if (rf_q[7:0] !== 8'h02) begin failures++; $display("FAIL wrap_r0 got=%h exp=02", rf_q[7:0]); end
      wait_halt("wrap");
   endtask

   task automatic test_stall;
      stall = 1'b1;
      kick(8'h50);
      for (int i = 0; i < 5; i++) begin
         checks++; if ({imem_req, busy, imem_addr} !== {2'b11, 8'h50}) begin failures++; $display("FAIL stall_hold%0d got=%b%b/%h exp=11/50", i, imem_req, busy, imem_addr); end
         @(negedge clk);
      end
      checks++; if (rf_q[31:24] !== 8'h00) begin failures++; $display("FAIL stall_r3 got=%h exp=00", rf_q[31:24]); end
      stall = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (rf_q[31:24] !== 8'h05) begin failures++; $display("FAIL fast_r3 got=%h exp=05", rf_q[31:24]); end
      checks++; if ({imem_req, imem_addr} !== {1'b1, 8'h51}) begin failures++; $display("FAIL fast_fetch got=%b/%h exp=1/51", imem_req, imem_addr); end
      @(negedge clk);
      checks++; if ({imem_req, busy} !== 2'b01) begin failures++; $display("FAIL fast_exec got=%b%b exp=01", imem_req, busy); end
      @(negedge clk);
      checks++; if (halted !== 1'b1) begin failures++; $display("FAIL fast_halt got=%b exp=1", halted); end
   endtask

   task automatic test_call;
      logic [7:0] exp_seq [10] = '{8'h60, 8'h70, 8'h80, 8'h90, 8'hA0, 8'h91, 8'h81, 8'h71, 8'h61, 8'h62};
      fetched.delete();
      rec = 1'b1;
      kick(8'h60);
      wait_halt("call");
      rec = 1'b0;
      checks++; if (fetched.size() !== 10) begin failures++; $display("FAIL call_len got=%0d exp=10", fetched.size()); end
      for (int i = 0; i < 10 && i < fetched.size(); i++) begin
         checks++; if (fetched[i] !== exp_seq[i]) begin failures++; $display("FAIL call_seq%0d got=%h exp=%h", i, fetched[i], exp_seq[i]); end
      end
      checks++; if (rf_q[23:16] !== 8'h10) begin failures++; $display("FAIL call_r2 got=%h exp=10", rf_q[23:16]); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL call_err got=%b exp=0", err); end
      kick(8'hB0);
      wait_halt("ovf");
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL ovf_err got=%b exp=1", err); end
      checks++; if (imem_addr !== 8'hC0) begin failures++; $display("FAIL ovf_pc got=%h exp=c0", imem_addr); end
      kick(8'h62);
      checks++; if ({err, busy} !== 2'b01) begin failures++; $display("FAIL clr_err got=%b%b exp=01", err, busy); end
      wait_halt("clr");
      checks++; if ({err, imem_addr} !== {1'b0, 8'h62}) begin failures++; $display("FAIL clr_end got=%b/%h exp=0/62", err, imem_addr); end
   endtask

   task automatic test_reset_mid;
      kick(8'hD0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (rf_q !== 32'h0) begin failures++; $display("FAIL mid_rf got=%h exp=0", rf_q); end
      checks++; if ({busy, halted, imem_req} !== 3'b000) begin failures++; $display("FAIL mid_state got=%b exp=000", {busy, halted, imem_req}); end
      checks++; if (imem_addr !== 8'h00) begin failures++; $display("FAIL mid_addr got=%h exp=00", imem_addr); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if ({rf_q, busy} !== 33'h0) begin failures++; $display("FAIL post_rst got=%h/%b exp=0/0", rf_q, busy); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) prog[i] = ins(RET, 2'd0, 8'h00);
      prog[8'h20] = ins(ADDI, 2'd1, 8'hF0);
      prog[8'h21] = ins(ADDI, 2'd1, 8'h20);
      prog[8'h22] = ins(SUBI, 2'd2, 8'h01);
      prog[8'h30] = ins(ADDI, 2'd0, 8'hFF);
      prog[8'h31] = ins(ADDI, 2'd0, 8'h01);
      prog[8'h32] = ins(JMPC, 2'd3, 8'h08);
      prog[8'h40] = ins(ADDI, 2'd0, 8'h01);
      prog[8'h41] = ins(JMPC, 2'd0, 8'h08);
      prog[8'hFF] = ins(ADDI, 2'd0, 8'h01);
      prog[8'h50] = ins(ADDI, 2'd3, 8'h05);
      prog[8'h60] = ins(CALL, 2'd1, 8'h70);
      prog[8'h70] = ins(CALL, 2'd0, 8'h80);
      prog[8'h80] = ins(CALL, 2'd0, 8'h90);
      prog[8'h90] = ins(CALL, 2'd0, 8'hA0);
      prog[8'h61] = ins(ADDI, 2'd2, 8'h11);
      prog[8'hB0] = ins(CALL, 2'd0, 8'hB4);
      prog[8'hB4] = ins(CALL, 2'd0, 8'hB8);
      prog[8'hB8] = ins(CALL, 2'd0, 8'hBC);
      prog[8'hBC] = ins(CALL, 2'd0, 8'hC0);
      prog[8'hC0] = ins(CALL, 2'd0, 8'hC4);
      prog[8'hD0] = ins(ADDI, 2'd3, 8'h05);
      test_reset;
      test_arith;
      test_branch;
      test_stall;
      test_call;
      test_reset_mid;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
